tnn_feature_frontend: RTL and testbench

//  Upstream stage of the 2-bit-input CGP classifier cores (8 features x 2 bits -> 1-bit class).

---
 rtl/tnn_feature_frontend.sv | 106 ++++++++++
 tb/tb_tnn_feature_frontend.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_feature_frontend.sv
// Streaming frontend for the 2-bit-input CGP classifier cores: quantizes raw
// feature beats against per-feature thresholds and returns the classifier bit.
module tnn_feature_frontend #(
  parameter int RAW_W  = 8,
  parameter int N_FEAT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_FEAT*3*RAW_W-1:0] cfg_thr,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [RAW_W-1:0]          s_data,
  input  logic                      s_last,
  output logic [2*N_FEAT-1:0]       cls_vec,
  input  logic                      cls_out,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_class,
  output logic                      m_err
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  typedef enum logic [1:0] {COLLECT, EVAL, HOLD} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  int unsigned          thr_base;
  logic [RAW_W-1:0]     t0, t1, t2;
  logic [1:0]           q;
  logic                 beat;
  logic                 at_end;
  logic [2*N_FEAT-1:0]  vec_next;

  always_comb begin
    thr_base = 32'(idx) * 32'(3 * RAW_W);
    t0 = cfg_thr[thr_base +: RAW_W];
    t1 = cfg_thr[thr_base + 32'(RAW_W) +: RAW_W];
    t2 = cfg_thr[thr_base + 32'(2 * RAW_W) +: RAW_W];
    if (s_data >= t2)      q = 2'd3;
    else if (s_data >= t1) q = 2'd2;
    else if (s_data >= t0) q = 2'd1;
    else                   q = 2'd0;
  end

  assign beat   = s_valid && s_ready && (state == COLLECT);
  assign at_end = (idx == IDX_W'(N_FEAT - 1));

  // A short frame zeroes every slot above the final beat in the same update.
  always_comb begin
    vec_next = cls_vec;
    for (int unsigned k = 0; k < N_FEAT; k++) begin
      if (k == 32'(idx))
        vec_next[2*k +: 2] = q;
      else if (k > 32'(idx) && s_last)
        vec_next[2*k +: 2] = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      idx     <= '0;
      cls_vec <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_class <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (beat) begin
            cls_vec <= vec_next;
            if (at_end || s_last) begin
              // idx is held here and only cleared on the result handshake
              state   <= EVAL;
              s_ready <= 1'b0;
              m_err   <= at_end ? ~s_last : 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        EVAL: begin
          m_class <= cls_out;
          m_valid <= 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            idx     <= '0;
            cls_vec <= '0;
            s_ready <= 1'b1;
            state   <= COLLECT;
          end
        end
        default: begin
          state   <= COLLECT;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_feature_frontend.sv
// Scoreboard bench for tnn_feature_frontend: a frame-level reference model
// queues expected results, a negedge monitor checks each result handshake.
module tb_tnn_feature_frontend;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [191:0] cfg_thr = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [7:0]   s_data = '0;
  logic         s_last = 1'b0;
  logic [15:0]  cls_vec;
  logic         cls_out;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_class;
  logic         m_err;

  tnn_feature_frontend #(.RAW_W(8), .N_FEAT(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_thr(cfg_thr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cls_vec(cls_vec), .cls_out(cls_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_err(m_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] vec;
    logic        cls;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  int         hs_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         clf_mode = 0;
  bit         rand_rdy = 0;
  logic [7:0] thr [8][3];
  logic [1:0] mq [8];
  int         mcnt = 0;
  logic [7:0] t1d [8] = '{8'd10, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255, 8'd0};

  // Stand-in classifier: mode 0 is the AND of feature 0's two bits.
  function automatic logic clf(input logic [15:0] v, input int mode);
    if (mode == 0) return v[1] & v[0];
    return (^v) | (v[3:2] == 2'b11);
  endfunction

  assign cls_out = clf(cls_vec, clf_mode);

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [1:0] quant(input logic [7:0] x, input int k);
    if (x >= thr[k][2]) return 2'd3;
    if (x >= thr[k][1]) return 2'd2;
    if (x >= thr[k][0]) return 2'd1;
    return 2'd0;
  endfunction

  task automatic load_thr();
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 3; j++)
        cfg_thr[(3*k+j)*8 +: 8] = thr[k][j];
  endtask

  task automatic set_thr_all(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int k = 0; k < 8; k++) begin
      thr[k][0] = a; thr[k][1] = b; thr[k][2] = c;
    end
    load_thr();
  endtask

  task automatic rand_thr();
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 3; j++)
        thr[k][j] = 8'($urandom_range(0, 255));
    load_thr();
  endtask

  // Frame model: a frame closes after 8 accepted beats or on s_last.
  task automatic model_accept(input logic [7:0] d, input bit last);
    exp_t e;
    mq[mcnt] = quant(d, mcnt);
    mcnt++;
    if (mcnt == 8 || last) begin
      e.vec = '0;
      for (int i = 0; i < mcnt; i++) e.vec[2*i +: 2] = mq[i];
      e.err = !(mcnt == 8 && last);
      e.cls = clf(e.vec, clf_mode);
      exp_q.push_back(e);
      mcnt = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input bit last);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: s_ready stuck low got 0 expected 1");
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    model_accept(d, last);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit with_last, input int f0);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = (i == 0 && f0 >= 0) ? 8'(f0) : 8'($urandom_range(0, 255));
      send(d, with_last && (i == len - 1));
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 m_ready = v;
    @(negedge clk);
  endtask

  task automatic wait_mvalid();
    int n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_vec++; n_err++;
      $display("FAIL mvalid_timeout: m_valid got 0 expected 1");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results pending expected 0", exp_q.size());
    end
  endtask

  task automatic stall_frame(input int f0, input logic exp_cls);
    set_ready(1'b0);
    send_frame(8, 1'b1, f0);
    wait_mvalid();
    chk("stall_class_const", m_class, exp_cls);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_m_valid", m_valid, 1);
      chk("stall_s_ready", s_ready, 0);
      if (exp_q.size() > 0) begin
        chk("stall_m_class", m_class, exp_q[0].cls);
        chk("stall_m_err", m_err, exp_q[0].err);
        chk("stall_cls_vec", cls_vec, exp_q[0].vec);
      end
    end
    set_ready(1'b1);
    @(negedge clk);
    chk("release_s_ready", s_ready, 1);
    chk("release_m_valid", m_valid, 0);
    chk("release_cls_vec", cls_vec, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && m_valid && m_ready) begin
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_result: vec %h cls %b with no frame pending", cls_vec, m_class);
      end else begin
        e = exp_q.pop_front();
        chk("res_cls_vec", cls_vec, e.vec);
        chk("res_m_class", m_class, e.cls);
        chk("res_m_err", m_err, e.err);
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    set_thr_all(8'd64, 8'd128, 8'd192);
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_class", m_class, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_cls_vec", cls_vec, 0);
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);

    // Reference frame with threshold-boundary values
    clf_mode = 0;
    for (int i = 0; i < 8; i++) send(t1d[i], i == 7);
    chk("t1_eval_m_valid", m_valid, 0);
    chk("t1_eval_s_ready", s_ready, 0);
    chk("t1_cls_vec", cls_vec, 16'h3E94);
    @(negedge clk);
    chk("t1_latency_m_valid", m_valid, 1);
    chk("t1_m_err", m_err, 0);
    chk("t1_cls_vec_hold", cls_vec, 16'h3E94);
    wait_idle();

    // Classifier bit capture with a stalled result port
    stall_frame(200, 1'b1);
    stall_frame(5, 1'b0);

    // Short frame, then an 8-beat frame missing s_last
    send_frame(3, 1'b1, -1);
    wait_mvalid();
    chk("short_m_err", m_err, 1);
    chk("short_upper_slots", 32'(cls_vec[15:6]), 0);
    wait_idle();
    send_frame(8, 1'b0, -1);
    wait_mvalid();
    chk("nolast_m_err", m_err, 1);
    wait_idle();

    // Asynchronous reset mid-frame
    send_frame(4, 1'b0, 200);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s_ready", s_ready, 1);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_class", m_class, 0);
    chk("arst_m_err", m_err, 0);
    chk("arst_cls_vec", cls_vec, 0);
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8, 1'b1, -1);
    wait_mvalid();
    chk("arst_next_m_err", m_err, 0);
    wait_idle();

    // Back-to-back frames with m_ready held high
    hs_q.delete();
    for (int f = 0; f < 4; f++) send_frame(8, 1'b1, -1);
    wait_idle();
    @(negedge clk);
    chk("b2b_result_count", hs_q.size(), 4);
    for (int i = 1; i < hs_q.size(); i++)
      chk("b2b_period", hs_q[i] - hs_q[i-1], 10);

    // Randomized frames, lengths 1..10, idle gaps and random backpressure
    clf_mode = 1;
    rand_thr();
    rand_rdy = 1;
    for (int f = 0; f < 60; f++) begin
      if (f % 15 == 14 && mcnt == 0) begin
        wait_idle();
        rand_thr();
      end
      for (int b = 0, len = $urandom_range(1, 10); b < len; b++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send(8'($urandom_range(0, 255)),
             (b == len - 1) && ($urandom_range(0, 3) != 0));
      end
    end
    wait_idle();
    rand_rdy = 0;
    set_ready(1'b1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
